trb_in_demux: RTL and testbench

//  Frame distributor in front of the NUM_TURBO turbo decoder cores: takes one 8-bit

---
 rtl/trb_in_demux.sv | 118 +++++++++++
 tb/tb_trb_in_demux.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trb_in_demux.sv
// rtl/trb_in_demux.sv - strict round-robin frame distributor feeding NUM_TURBO decoder cores
module trb_in_demux #(
    parameter int NUM_TURBO = 2,
    parameter int FRAME_LEN = 128,
    parameter int CW        = $clog2(NUM_TURBO)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             st_data_in,
    input  logic                   st_valid_in,
    input  logic                   st_sop_in,
    input  logic                   st_eop_in,
    output logic                   st_ready_out,
    output logic [8*NUM_TURBO-1:0] st_data_out,
    output logic [NUM_TURBO-1:0]   st_valid_out,
    output logic [NUM_TURBO-1:0]   st_sop_out,
    output logic [NUM_TURBO-1:0]   st_eop_out,
    input  logic [NUM_TURBO-1:0]   st_ready_in,
    output logic [CW-1:0]          cur_core,
    output logic                   err_len,
    output logic                   err_sop
);

    localparam logic [10:0] LAST_BEAT = 11'(FRAME_LEN - 1);

    typedef enum logic {
        IDLE = 1'b0,
        PASS = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [CW-1:0]          ptr;
    logic [CW-1:0]          ptr_inc;
    logic [10:0]            cnt;

    logic [8*NUM_TURBO-1:0] data_q;
    logic [NUM_TURBO-1:0]   valid_q;
    logic [NUM_TURBO-1:0]   sop_q;
    logic [NUM_TURBO-1:0]   eop_q;

    logic                   accept;
    logic                   drop;
    logic                   fwd;
    logic                   frame_end;
    logic                   len_err;

    // The current lane register may refill only when empty or draining this cycle.
    always_comb begin
        st_ready_out = (state == PASS) && (!valid_q[ptr] || st_ready_in[ptr]);
        accept       = st_valid_in && st_ready_out;
        drop         = accept && (cnt == 11'd0) && !st_sop_in;
        fwd          = accept && !drop;
        frame_end    = fwd && (st_eop_in || (cnt == LAST_BEAT));
        len_err      = fwd && (((cnt != 11'd0) && st_sop_in) ||
                               (frame_end && ((cnt != LAST_BEAT) || !st_eop_in)));
        ptr_inc      = (ptr == CW'(NUM_TURBO - 1)) ? '0 : ptr + 1'b1;
    end

    // Strict order: IDLE waits on the pointed-to core only, never skipping ahead.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (st_ready_in[ptr]) state_nxt = PASS;
            PASS: if (frame_end)        state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            cnt     <= 11'd0;
            err_len <= 1'b0;
            err_sop <= 1'b0;
        end else begin
            state   <= state_nxt;
            err_len <= len_err;
            err_sop <= drop;
            if (fwd) begin
                cnt <= frame_end ? 11'd0 : cnt + 11'd1;
            end
            if (frame_end) begin
                ptr <= ptr_inc;
            end
        end
    end

    // A lane left holding the previous frame's last beat keeps draining after ptr moves on.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= '0;
            sop_q   <= '0;
            eop_q   <= '0;
        end else begin
            for (int k = 0; k < NUM_TURBO; k++) begin
                if (valid_q[k] && st_ready_in[k]) begin
                    valid_q[k] <= 1'b0;
                end
                if (fwd && (ptr == CW'(k))) begin
                    valid_q[k]        <= 1'b1;
                    data_q[8*k +: 8]  <= st_data_in;
                    sop_q[k]          <= (cnt == 11'd0);
                    eop_q[k]          <= frame_end;
                end
            end
        end
    end

    assign st_data_out  = data_q;
    assign st_valid_out = valid_q;
    assign st_sop_out   = sop_q;
    assign st_eop_out   = eop_q;
    assign cur_core     = ptr;

endmodule

// File: tb/tb_trb_in_demux.sv
// tb/tb_trb_in_demux.sv - scoreboard bench for trb_in_demux
module tb_trb_in_demux;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  st_data_in;
    logic        st_valid_in;
    logic        st_sop_in;
    logic        st_eop_in;
    logic        st_ready_out;
    logic [15:0] st_data_out;
    logic [1:0]  st_valid_out;
    logic [1:0]  st_sop_out;
    logic [1:0]  st_eop_out;
    logic [1:0]  st_ready_in;
    logic [0:0]  cur_core;
    logic        err_len;
    logic        err_sop;

    trb_in_demux #(.NUM_TURBO(2), .FRAME_LEN(128), .CW(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .st_data_in   (st_data_in),
        .st_valid_in  (st_valid_in),
        .st_sop_in    (st_sop_in),
        .st_eop_in    (st_eop_in),
        .st_ready_out (st_ready_out),
        .st_data_out  (st_data_out),
        .st_valid_out (st_valid_out),
        .st_sop_out   (st_sop_out),
        .st_eop_out   (st_eop_out),
        .st_ready_in  (st_ready_in),
        .cur_core     (cur_core),
        .err_len      (err_len),
        .err_sop      (err_sop)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       sop;
        logic       eop;
    } beat_t;

    beat_t exp_q0[$];
    beat_t exp_q1[$];

    int checks = 0;
    int errors = 0;
    int exp_err_len = 0;
    int exp_err_sop = 0;
    int obs_err_len = 0;
    int obs_err_sop = 0;
    bit tog_en = 1'b0;
    int tog_cnt = 0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_beat(input int k);
        beat_t got;
        beat_t exp;
        bit    empty;
        got   = {st_data_out[8*k +: 8], st_sop_out[k], st_eop_out[k]};
        empty = (k == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0);
        checks++;
        if (empty) begin
            errors++;
            $display("FAIL lane%0d_unexpected: got d=%0d sop=%0b eop=%0b expected no beat",
                     k, got.d, got.sop, got.eop);
        end else begin
            exp = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            if (got != exp) begin
                errors++;
                $display("FAIL lane%0d_beat: got d=%0d sop=%0b eop=%0b expected d=%0d sop=%0b eop=%0b",
                         k, got.d, got.sop, got.eop, exp.d, exp.sop, exp.eop);
            end
        end
    endtask

    // Monitor: a transfer happens on the next edge whenever valid and ready are both high.
    always @(negedge clk) begin
        if (!rst) begin
            if (err_len) obs_err_len++;
            if (err_sop) obs_err_sop++;
            for (int k = 0; k < 2; k++) begin
                if (st_valid_out[k] && st_ready_in[k]) check_beat(k);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (tog_en) begin
            tog_cnt++;
            if (tog_cnt % 3 == 0) st_ready_in[0] = ~st_ready_in[0];
        end
    end

    task automatic send_beat(input logic [7:0] d, input logic sop, input logic eop,
                             input bit exp_fwd, input int lane,
                             input logic exp_sop, input logic exp_eop);
        bit acc = 1'b0;
        int waited = 0;
        st_data_in  = d;
        st_sop_in   = sop;
        st_eop_in   = eop;
        st_valid_in = 1'b1;
        while (!acc && waited < 3000) begin
            @(negedge clk);
            if (st_ready_out) begin
                acc = 1'b1;
                if (exp_fwd) begin
                    if (lane == 0) exp_q0.push_back({d, exp_sop, exp_eop});
                    else           exp_q1.push_back({d, exp_sop, exp_eop});
                end
            end
            @(posedge clk);
            #1;
            waited++;
        end
        st_valid_in = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no ready after %0d cycles expected ready", waited);
        end
    endtask

    task automatic send_frame(input int lane, input int nbeats, input int eop_at,
                              input int exp_eop_at, input int base);
        for (int i = 0; i < nbeats; i++) begin
            send_beat(8'(base + i), (i == 0), (i == eop_at), 1'b1, lane,
                      (i == 0), (i == exp_eop_at));
        end
    endtask

    task automatic check_errs(input string tag);
        repeat (4) @(posedge clk);
        #1;
        chk({tag, "_err_len"}, obs_err_len, exp_err_len);
        chk({tag, "_err_sop"}, obs_err_sop, exp_err_sop);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_valid_out"}, int'(st_valid_out), 0);
        chk({tag, "_data_out"},  int'(st_data_out),  0);
        chk({tag, "_sop_eop"},   int'({st_sop_out, st_eop_out}), 0);
        chk({tag, "_ready_out"}, int'(st_ready_out), 0);
        chk({tag, "_cur_core"},  int'(cur_core),     0);
        chk({tag, "_err"},       int'({err_len, err_sop}), 0);
    endtask

    initial begin
        int hi_cnt;
        rst         = 1'b1;
        st_data_in  = 8'd0;
        st_valid_in = 1'b0;
        st_sop_in   = 1'b0;
        st_eop_in   = 1'b0;
        st_ready_in = 2'b11;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // T1: four good frames alternate lanes 0,1,0,1
        for (int f = 0; f < 4; f++) send_frame(f % 2, 128, 127, 127, f * 16);
        chk("t1_cur_core", int'(cur_core), 0);
        check_errs("t1");

        // T2: core1 not ready; frame 1 must wait rather than go to core0
        send_frame(0, 128, 127, 127, 100);
        chk("t2_cur_core", int'(cur_core), 1);
        st_ready_in = 2'b01;
        st_data_in  = 8'd200;
        st_sop_in   = 1'b1;
        st_eop_in   = 1'b0;
        st_valid_in = 1'b1;
        hi_cnt = 0;
        repeat (500) begin
            @(negedge clk);
            if (st_ready_out || st_valid_out[1]) hi_cnt++;
        end
        @(posedge clk);
        #1;
        chk("t2_stalled", hi_cnt, 0);
        st_ready_in = 2'b11;
        send_frame(1, 128, 127, 127, 200);
        check_errs("t2");

        // T3: lane0 backpressure toggling mid-frame, data 0..127
        tog_cnt = 0;
        tog_en  = 1'b1;
        send_frame(0, 128, 127, 127, 0);
        tog_en = 1'b0;
        #1;
        st_ready_in = 2'b11;
        check_errs("t3");
        chk("t3_lane0_drained", exp_q0.size(), 0);

        // T4: early eop at beat 63, next frame to next core
        send_frame(1, 64, 63, 63, 50);
        exp_err_len++;
        send_frame(0, 128, 127, 127, 7);
        check_errs("t4");

        // T5: missing eop forced at 127, following sop-less beats dropped
        send_frame(1, 128, -1, 127, 30);
        exp_err_len++;
        for (int i = 0; i < 3; i++) begin
            send_beat(8'(i + 240), 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
            exp_err_sop++;
        end
        check_errs("t5");
        chk("t5_cur_core", int'(cur_core), 0);

        // T6: reset mid-frame, then a complete frame to lane0
        send_frame(0, 50, -1, -1, 60);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_idle_outputs("t6_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q0.delete();
        exp_q1.delete();
        send_frame(0, 128, 127, 127, 90);
        check_errs("t6");
        chk("t6_cur_core", int'(cur_core), 1);

        repeat (10) @(posedge clk);
        #1;
        chk("end_q0_empty", exp_q0.size(), 0);
        chk("end_q1_empty", exp_q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
